// File: rtl/mp_pkg.sv
// Shared definitions for the max-pool read engine: lane geometry,
// read FSM encoding and the per-lane signed max helper.
package mp_pkg;

  localparam int CH_W   = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = CH_W * LANES;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_EVEN = 2'd1,
    ST_READ_ODD  = 2'd2,
    ST_DRAIN     = 2'd3
  } mp_rd_state_t;

  // Lane-wise signed max of two packed words; lanes never interact.
  function automatic logic [WORD_W-1:0] lane_max2(input logic [WORD_W-1:0] a,
                                                  input logic [WORD_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      if ($signed(a[k*CH_W +: CH_W]) > $signed(b[k*CH_W +: CH_W]))
        r[k*CH_W +: CH_W] = a[k*CH_W +: CH_W];
      else
        r[k*CH_W +: CH_W] = b[k*CH_W +: CH_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/mp_lane_max4.sv
// Combinational 4-input signed max, applied independently per lane.
module mp_lane_max4
  import mp_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] y
);

  // Balanced tree of two-input lane maxima.
  always_comb begin
    y = lane_max2(lane_max2(a, b), lane_max2(c, d));
  end

endmodule

// File: rtl/mp_pool_reader.sv
// Read-side engine for the max-pool line-buffer pair.
// Reads even/odd rows pixel pairs, computes a 2x2 stride-2 signed max per
// int8 lane and streams pooled words over valid/ready.
// Optional feature: define MP_RELU_EN to clamp each output lane at zero.
//
// Handshake: a pooled word transfers on a rising edge where pool_valid and
// pool_ready are both high; pool_valid and pool_dout hold steady until then.
// Bank strobes dout_valid/dout_valid_next are always equal; bank data arrives
// the cycle after a strobe.
module mp_pool_reader
  import mp_pkg::*;
#(
  parameter int CH_W    = 8,
  parameter int WIDTH_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH_W-1:0] ifm_width,
  input  logic               dout_full,
  input  logic [31:0]        dout,
  input  logic [31:0]        dout_next,
  output logic               dout_valid,
  output logic               dout_valid_next,
  output logic [31:0]        pool_dout,
  output logic               pool_valid,
  input  logic               pool_ready,
  output logic               row_done,
  output logic [1:0]         state_dbg
);

  localparam int OUT_W = LANES * CH_W;

  mp_rd_state_t       state;
  mp_rd_state_t       nstate;
  logic [WIDTH_W-1:0] width_lat;
  logic [WIDTH_W-1:0] width_even;
  logic [WIDTH_W-1:0] col;
  logic               strobe;
  logic               finish;
  logic               word_clear;
  logic               even_d;
  logic               odd_d;
  logic               disc_done;
  logic [1:0]         cool;
  logic [OUT_W-1:0]   pair_reg;
  logic [OUT_W-1:0]   max4_y;
  logic [OUT_W-1:0]   pool_next;

  assign width_even = {width_lat[WIDTH_W-1:1], 1'b0};
  // Nothing pending: no odd-row data in flight and output empty or leaving now.
  assign word_clear = !odd_d && (!pool_valid || pool_ready);
  assign dout_valid      = strobe;
  assign dout_valid_next = strobe;
  assign state_dbg       = state;

  mp_lane_max4 u_max4 (
    .a (pair_reg),
    .b (pair_reg),
    .c (dout),
    .d (dout_next),
    .y (max4_y)
  );

  // Optional zero clamp on every lane of the pooled result.
  always_comb begin
    pool_next = max4_y;
`ifdef MP_RELU_EN
    for (int k = 0; k < LANES; k++) begin
      if (max4_y[k*CH_W + CH_W - 1])
        pool_next[k*CH_W +: CH_W] = '0;
    end
`endif
  end

  // Next-state and strobe decode.
  always_comb begin
    nstate = state;
    strobe = 1'b0;
    finish = 1'b0;
    case (state)
      ST_IDLE: begin
        // cool keeps at least two idle cycles after row_done.
        if (dout_full && cool == 2'd0) begin
          if (ifm_width < WIDTH_W'(2)) nstate = ST_DRAIN;
          else                         nstate = ST_READ_EVEN;
        end
      end
      ST_READ_EVEN: begin
        strobe = 1'b1;
        nstate = ST_READ_ODD;
      end
      ST_READ_ODD: begin
        // Only one pooled word may be in flight, so wait for the slot.
        if (!pool_valid || pool_ready) begin
          strobe = 1'b1;
          if ((col + 1'b1) < width_even) nstate = ST_READ_EVEN;
          else                           nstate = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Odd width: one strobe pair discards the trailing pixel.
        strobe = width_lat[0] && !disc_done;
        if (word_clear) begin
          finish = 1'b1;
          nstate = ST_IDLE;
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // State register, counters and bookkeeping flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      width_lat <= '0;
      col       <= '0;
      even_d    <= 1'b0;
      odd_d     <= 1'b0;
      disc_done <= 1'b0;
      cool      <= 2'd0;
      row_done  <= 1'b0;
    end else begin
      state  <= nstate;
      even_d <= strobe && (state == ST_READ_EVEN);
      odd_d  <= strobe && (state == ST_READ_ODD);
      row_done <= finish;
      if (state == ST_IDLE && nstate != ST_IDLE) begin
        width_lat <= ifm_width;
        col       <= '0;
        disc_done <= 1'b0;
      end else if (strobe && state != ST_DRAIN) begin
        col <= col + 1'b1;
      end
      if (state == ST_DRAIN && strobe) disc_done <= 1'b1;
      if (finish)             cool <= 2'd2;
      else if (cool != 2'd0)  cool <= cool - 2'd1;
    end
  end

  // Pooling datapath: vertical/horizontal pair max, then output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_reg   <= '0;
      pool_dout  <= '0;
      pool_valid <= 1'b0;
    end else begin
      if (even_d) pair_reg <= lane_max2(dout, dout_next);
      if (odd_d) begin
        pool_dout  <= pool_next;
        pool_valid <= 1'b1;
      end else if (pool_valid && pool_ready) begin
        pool_valid <= 1'b0;
      end
    end
  end

endmodule
